// File: rtl/frame_tx_pkg.sv
// Shared types and constants for the serial frame transmitter.
// FRAME_TX_PARITY_EN adds the even-parity state and lengthens the frame to 11 bits.
package frame_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef FRAME_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } frame_state_e;

    localparam int CLKS_PER_BIT_DEF = 4;
    localparam int FRAME_BITS_NOPAR = 10;
    localparam int FRAME_BITS_PAR   = 11;

`ifdef FRAME_TX_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PAR;
`else
    localparam int FRAME_BITS = FRAME_BITS_NOPAR;
`endif

    localparam logic [3:0] LAST_DATA_IDX = 4'd8;
    localparam logic [3:0] STOP_IDX      = 4'(FRAME_BITS - 1);

endpackage

// File: rtl/frame_tx_if.sv
// Pin bundle of the transmitter: parallel byte, strobe and status/serial outputs.
interface frame_tx_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ui_in, output uio_in, input uo_out, input uio_out, input uio_oe);
    modport slave  (input ui_in, input uio_in, output uo_out, output uio_out, output uio_oe);
endinterface

// File: rtl/frame_tx_baud.sv
// Bit-period down-counter; o_tick marks the last enabled cycle of a bit.
module frame_tx_baud
    import frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_run,
    input  logic i_reload,
    output logic o_tick
);
    localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (i_reload) begin
                r_cnt <= RELOAD;
            end else if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    assign o_tick = i_en & i_run & (r_cnt == 8'd0);

endmodule

// File: rtl/tt_um_frame_tx.sv
// Serial frame transmitter: start, 8 data bits LSB first, optional even parity, stop.
// Parity bit is present only when FRAME_TX_PARITY_EN is defined.
//   state  | meaning
//   IDLE   | line high, waiting for a strobe rising edge
//   START  | start bit (0)
//   DATA   | data bits, shift register moves right each bit
//   PARITY | even parity of the captured byte
//   STOP   | stop bit (1); done pulses as it ends
module tt_um_frame_tx
    import frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    frame_tx_if.slave  bus
);
    frame_state_e r_state, w_state_n;
    logic [7:0]   r_shift, w_shift_n;
    logic [3:0]   r_idx, w_idx_n;
    logic         r_tx, w_tx_n;
    logic         r_done, w_done_n;
    logic         r_strobe, r_armed;
    logic         w_load, w_tick, w_run, w_reload;
    logic         w_unused_uio;
`ifdef FRAME_TX_PARITY_EN
    logic         r_parity, w_parity_n;
`endif

    // r_armed forces a fresh low strobe after reset before a load can be seen
    assign w_load   = bus.uio_in[0] & ~r_strobe & r_armed & (r_state == S_IDLE);
    assign w_run    = (r_state != S_IDLE);
    assign w_reload = w_load | w_tick;

    frame_tx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (ena),
        .i_run    (w_run),
        .i_reload (w_reload),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_idx    <= '0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
            r_strobe <= 1'b0;
            r_armed  <= 1'b0;
`ifdef FRAME_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (ena) begin
            r_state  <= w_state_n;
            r_shift  <= w_shift_n;
            r_idx    <= w_idx_n;
            r_tx     <= w_tx_n;
            r_done   <= w_done_n;
            r_strobe <= bus.uio_in[0];
            r_armed  <= r_armed | ~bus.uio_in[0];
`ifdef FRAME_TX_PARITY_EN
            r_parity <= w_parity_n;
`endif
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_shift_n = r_shift;
        w_idx_n   = r_idx;
        w_tx_n    = r_tx;
        w_done_n  = 1'b0;
`ifdef FRAME_TX_PARITY_EN
        w_parity_n = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_tx_n  = 1'b1;
                w_idx_n = 4'd0;
                if (w_load) begin
                    w_state_n = S_START;
                    w_shift_n = bus.ui_in;
                    w_tx_n    = 1'b0;
`ifdef FRAME_TX_PARITY_EN
                    w_parity_n = ^bus.ui_in;
`endif
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_n = S_DATA;
                    w_tx_n    = r_shift[0];
                    w_idx_n   = 4'd1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_n = {1'b0, r_shift[7:1]};
                    if (r_idx == LAST_DATA_IDX) begin
`ifdef FRAME_TX_PARITY_EN
                        w_state_n = S_PARITY;
                        w_tx_n    = r_parity;
                        w_idx_n   = LAST_DATA_IDX + 4'd1;
`else
                        w_state_n = S_STOP;
                        w_tx_n    = 1'b1;
                        w_idx_n   = STOP_IDX;
`endif
                    end else begin
                        w_tx_n  = r_shift[1];
                        w_idx_n = r_idx + 4'd1;
                    end
                end
            end
`ifdef FRAME_TX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_state_n = S_STOP;
                    w_tx_n    = 1'b1;
                    w_idx_n   = STOP_IDX;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    w_state_n = S_IDLE;
                    w_tx_n    = 1'b1;
                    w_idx_n   = 4'd0;
                    w_done_n  = 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_tx_n    = 1'b1;
                w_idx_n   = 4'd0;
            end
        endcase
    end

    assign w_unused_uio = ^bus.uio_in[7:1];
    assign bus.uo_out   = {1'b0, r_idx, r_done, w_run, r_tx};
    assign bus.uio_out  = 8'h00;
    assign bus.uio_oe   = 8'h00;

endmodule

// File: tb/tb_tt_um_frame_tx.sv
// Directed and randomized frames checked against a bit-position model of the serial frame.
module tb_tt_um_frame_tx;
    localparam int CPB = 4;
`ifdef FRAME_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic  clk = 1'b0;
    logic  rst_n = 1'b1;
    logic  ena = 1'b0;
    int    checks = 0;
    int    errors = 0;
    string phase = "init";

    frame_tx_if u_if ();

    tt_um_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    // Frame bit k: 0 = start, 1..8 = data LSB first, then parity (if present), last = stop.
    function automatic logic ref_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (NB == 11 && k == 9) return logic'($countones(d) % 2);
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed %0h expected %0h", phase, name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_strobe(input logic v);
        u_if.uio_in = {7'($urandom), v};
    endtask

    task automatic check_cycle(input logic [7:0] d, input int c);
        chk("tx",   8'(u_if.uo_out[0]),   8'(ref_bit(d, c / CPB)));
        chk("busy", 8'(u_if.uo_out[1]),   8'd1);
        chk("done", 8'(u_if.uo_out[2]),   8'd0);
        chk("idx",  8'(u_if.uo_out[7:3]), 8'(c / CPB));
    endtask

    task automatic check_idle();
        chk("tx",   8'(u_if.uo_out[0]),   8'd1);
        chk("busy", 8'(u_if.uo_out[1]),   8'd0);
        chk("done", 8'(u_if.uo_out[2]),   8'd0);
        chk("idx",  8'(u_if.uo_out[7:3]), 8'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check_idle();
        end
    endtask

    // Caller leaves the strobe low for at least one edge before calling.
    task automatic frame(input logic [7:0] d, input int stall_at, input int drop_at, input int rise_at);
        u_if.ui_in = d;
        set_strobe(1'b1);
        step();
        for (int c = 0; c < NB * CPB; c++) begin
            check_cycle(d, c);
            if (c == stall_at) begin
                ena = 1'b0;
                for (int s = 0; s < 7; s++) begin
                    step();
                    check_cycle(d, c);
                end
                ena = 1'b1;
            end
            if (c == drop_at) set_strobe(1'b0);
            if (c == rise_at) set_strobe(1'b1);
            u_if.ui_in = 8'($urandom);
            step();
        end
        chk("end_done", 8'(u_if.uo_out[2]),   8'd1);
        chk("end_busy", 8'(u_if.uo_out[1]),   8'd0);
        chk("end_tx",   8'(u_if.uo_out[0]),   8'd1);
        chk("end_idx",  8'(u_if.uo_out[7:3]), 8'd0);
    endtask

    initial begin
        u_if.ui_in  = 8'h00;
        u_if.uio_in = 8'h00;
        ena = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        phase = "reset";
        check_idle();
        chk("uio_out", u_if.uio_out, 8'h00);
        chk("uio_oe",  u_if.uio_oe,  8'h00);
        step();
        step();
        rst_n = 1'b1;
        idle(2);

        phase = "basic_a5";
        frame(8'hA5, -1, 20, -1);
        idle(2);

        phase = "strobe_reject";
        frame(8'h3C, -1, 10, 12);
        idle(3);
        set_strobe(1'b0);
        idle(1);

        phase = "ena_stall";
        frame(8'h96, 4 * CPB + 1, 30, -1);
        idle(1);

`ifdef FRAME_TX_PARITY_EN
        phase = "parity_a5";
        frame(8'hA5, -1, 5, -1);
        idle(1);
        phase = "parity_01";
        frame(8'h01, -1, 5, -1);
        idle(1);
`endif

        phase = "b2b_00";
        frame(8'h00, -1, 8, -1);
        phase = "b2b_ff";
        frame(8'hFF, -1, 8, -1);
        idle(2);

        phase = "reset_mid";
        u_if.ui_in = 8'h5A;
        set_strobe(1'b1);
        step();
        for (int c = 0; c < 15; c++) begin
            check_cycle(8'h5A, c);
            step();
        end
        rst_n = 1'b0;
        #1;
        check_idle();
        step();
        step();
        rst_n = 1'b1;
        phase = "reset_held_strobe";
        idle(NB * CPB + 4);
        set_strobe(1'b0);
        idle(1);
        phase = "after_reset";
        frame(8'h5A, -1, 3, -1);
        idle(1);

        phase = "random";
        for (int r = 0; r < 6; r++) begin
            logic [7:0] d;
            int stall;
            d = 8'($urandom);
            stall = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NB * CPB - 1)) : -1;
            frame(d, stall, int'($urandom_range(0, NB * CPB - 1)), -1);
            idle(int'($urandom_range(1, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
